lcd_cmd_sched: RTL and testbench
================================

# lcd_cmd_sched

Command scheduler sitting in front of the LCD_CTRL image-window engine. Two requesters queue 3-bit LCD commands into private FIFOs. The block arbitrates round-robin and issues one command at a time on LCD_CTRL's cmd/cmd_valid/busy handshake. For a Load command (3'd1) it streams the 64-pixel 8x8 image from a synchronous image memory onto datain.

## Interface
- FIFO_DEPTH, 4, entries per requester FIFO (power of two, ≥2)
- N_PIX, 64, pixels streamed per Load
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0_cmd  in  3  requester 0 command
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 FIFO not full
- req1_cmd, req1_valid, req1_ready  as requester 0
- drop  out  1  one-cycle pulse: a command value 6/7 was discarded
- img_rd_en  out  1  image memory read strobe
- img_rd_addr  out  6  image memory address
- img_rd_data  in  8  read data, valid the cycle after img_rd_en
- lcd_cmd  out  3  command to LCD_CTRL
- lcd_cmd_valid  out  1  one-cycle command strobe
- lcd_datain  out  8  pixel data to LCD_CTRL
- lcd_busy  in  1  LCD_CTRL busy
- grant_id  out  1  source of the last issued command
- idle  out  1  FSM in IDLE and both FIFOs empty

## Operation
- Enqueue: push when reqN_valid && reqN_ready; reqN_ready = !fullN, from registered count. Values 0–5 are stored. Values 6/7 are not stored; pulse drop the next cycle (OR of both ports).
- FSM states: IDLE, ISSUE, LOAD, HOLD.
- IDLE: if !lcd_busy and at least one FIFO head is valid, select the winner, pop it, register lcd_cmd, and go to ISSUE. Otherwise stay in IDLE; lcd_busy is sampled only here.
- Arbitration: round-robin on a 1-bit last-grant pointer (reset 1, so requester 0 wins first). If only one head is valid, it wins. If both are valid, the requester that is not last-grant wins. Pointer and grant_id update on pop.
- ISSUE (1 cycle): lcd_cmd_valid=1. If cmd==1, img_rd_en=1 with addr 0 and the next state is LOAD; otherwise the next state is HOLD.
- LOAD (N_PIX cycles): lcd_datain = img_rd_data (combinational mux; 0 outside LOAD). img_rd_en=1 and addr increments for read k+1 while pixel k is presented. Read k=N_PIX-1 is the last read; addr does not wrap. Then go to HOLD.
- HOLD (1 cycle): guard cycle so LCD_CTRL can raise busy. Then go to IDLE.
- Reset (any state, including mid-LOAD): FIFOs emptied, FSM→IDLE, load aborted. No partial resume.
- Simultaneous push and pop on the same FIFO: both take effect, count unchanged. A push into an empty FIFO is not visible to arbitration until the next cycle.

## Timing
- Reset values: lcd_cmd 0, lcd_cmd_valid 0, lcd_datain 0, img_rd_en 0, img_rd_addr 0, drop 0, grant_id 0, req0/1_ready 1, idle 1.
- Command pushed in cycle t, with the FSM in IDLE and busy low: lcd_cmd_valid high in cycle t+2.
- Load: pixel k is on lcd_datain in cycle c+1+k, where c is the cmd_valid cycle. The 64 pixels occupy c+1..c+64; HOLD is c+65; IDLE is c+66.
- Non-load: ISSUE c, HOLD c+1, IDLE c+2. Earliest back-to-back cmd_valid with busy low is c+3.
- lcd_cmd_valid is never high in two consecutive cycles. lcd_cmd holds its value until the next issue.

## Structure
- Package lcd_pkg:
  - CMD_LOAD=3'd1
  - command constants 0–5
  - state enum {IDLE, ISSUE, LOAD, HOLD}
  - N_PIX and address-width constants
- Sub-module lcd_cmd_fifo (3-bit, FIFO_DEPTH, count-based full/empty), instantiated once per requester.
- Arbiter, FSM and address counter live in the top module.

## Test plan
- Reset, then req0 pushes 3'd1 with memory holding pixel k = k: cmd_valid 2 cycles later; lcd_datain 0x00..0x3F on 64 consecutive cycles; idle returns at c+66.
- Both requesters push 4 commands each in the same cycles (req0: 0,2,3,4; req1: 5,0,2,3), busy low: issue order 0,5,2,0,3,2,4,3; grant_id alternates 0,1,0,1…
- req1 pushes 5 commands back-to-back with busy held high: req1_ready drops after the 4th push; the 5th is held off; no cmd_valid until busy falls.
- Push 3'd6 and 3'd7: drop pulses twice, FIFO count stays 0, nothing issued.
- Assert reset during LOAD at pixel 20: all outputs return to reset values immediately; after release, no further datain is driven and the FIFOs are empty.
- Busy rises in HOLD after a shift command (3'd2) and stays high for 10 cycles: the next queued command is issued 2 cycles after busy falls.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD command scheduler.
package lcd_pkg;

    localparam int unsigned LCD_N_PIX = 64;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned CMD_W     = 3;

    // LCD_CTRL command encodings; 6 and 7 are not legal commands.
    localparam logic [CMD_W-1:0] CMD_WRITE   = 3'd0;
    localparam logic [CMD_W-1:0] CMD_LOAD    = 3'd1;
    localparam logic [CMD_W-1:0] CMD_SHIFT_R = 3'd2;
    localparam logic [CMD_W-1:0] CMD_SHIFT_L = 3'd3;
    localparam logic [CMD_W-1:0] CMD_SHIFT_U = 3'd4;
    localparam logic [CMD_W-1:0] CMD_SHIFT_D = 3'd5;

    typedef enum logic [1:0] {IDLE, ISSUE, LOAD, HOLD} state_e;

    // True for command values that LCD_CTRL understands.
    function automatic logic cmd_storable(input logic [CMD_W-1:0] cmd);
        return (cmd <= CMD_SHIFT_D);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Per-requester command FIFO with count-based full/empty flags.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [CMD_W-1:0] i_wdata,
    output logic [CMD_W-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rptr];

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Two-requester round-robin command scheduler in front of LCD_CTRL; streams the
// image memory onto datain for Load commands.
module lcd_cmd_sched
    import lcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned N_PIX      = LCD_N_PIX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  req0_cmd,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CMD_W-1:0]  req1_cmd,
    input  logic              req1_valid,
    output logic              req1_ready,
    output logic              drop,
    output logic              img_rd_en,
    output logic [ADDR_W-1:0] img_rd_addr,
    input  logic [7:0]        img_rd_data,
    output logic [CMD_W-1:0]  lcd_cmd,
    output logic              lcd_cmd_valid,
    output logic [7:0]        lcd_datain,
    input  logic              lcd_busy,
    output logic              grant_id,
    output logic              idle
);
    localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W + 1)'(N_PIX - 1);
    localparam logic [ADDR_W:0] PIX_ONE  = (ADDR_W + 1)'(1);

    state_e           r_state;
    state_e           w_state_d;
    logic [CMD_W-1:0] r_cmd;
    logic             r_gid;
    logic             r_last;
    logic             r_drop;
    logic [ADDR_W:0]  r_pix;

    logic             w_full0, w_empty0, w_full1, w_empty1;
    logic [CMD_W-1:0] w_rdata0, w_rdata1;
    logic             w_acc0, w_acc1;
    logic             w_push0, w_push1;
    logic             w_bad;
    logic             w_take;
    logic             w_sel;
    logic             w_pop0, w_pop1;
    logic [CMD_W-1:0] w_sel_cmd;

    // Enqueue side: illegal command values are accepted but discarded.
    assign req0_ready = !w_full0;
    assign req1_ready = !w_full1;
    assign w_acc0     = req0_valid && !w_full0;
    assign w_acc1     = req1_valid && !w_full1;
    assign w_push0    = w_acc0 && cmd_storable(req0_cmd);
    assign w_push1    = w_acc1 && cmd_storable(req1_cmd);
    assign w_bad      = (w_acc0 && !cmd_storable(req0_cmd)) || (w_acc1 && !cmd_storable(req1_cmd));

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo0 (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push0),
        .i_pop   (w_pop0),
        .i_wdata (req0_cmd),
        .o_rdata (w_rdata0),
        .o_full  (w_full0),
        .o_empty (w_empty0)
    );

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo1 (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push1),
        .i_pop   (w_pop1),
        .i_wdata (req1_cmd),
        .o_rdata (w_rdata1),
        .o_full  (w_full1),
        .o_empty (w_empty1)
    );

    // Round-robin pick: a lone valid head wins; with two, the non-last-grant side wins.
    always_comb begin
        w_take    = (r_state == IDLE) && !lcd_busy && (!w_empty0 || !w_empty1);
        w_sel     = (!w_empty0 && !w_empty1) ? !r_last : w_empty0;
        w_pop0    = w_take && !w_sel;
        w_pop1    = w_take && w_sel;
        w_sel_cmd = w_sel ? w_rdata1 : w_rdata0;
    end

    // Next-state logic; busy only gates the IDLE -> ISSUE transition.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (w_take) w_state_d = ISSUE;
            ISSUE:   w_state_d = (r_cmd == CMD_LOAD) ? LOAD : HOLD;
            LOAD:    if (r_pix == LAST_PIX) w_state_d = HOLD;
            HOLD:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // FSM state, issued command, grant tracking, pixel counter and drop pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cmd   <= '0;
            r_gid   <= 1'b0;
            r_last  <= 1'b1;
            r_drop  <= 1'b0;
            r_pix   <= '0;
        end else begin
            r_state <= w_state_d;
            r_drop  <= w_bad;
            if (w_take) begin
                r_cmd  <= w_sel_cmd;
                r_gid  <= w_sel;
                r_last <= w_sel;
            end
            if (r_state == ISSUE) begin
                r_pix <= '0;
            end else if (r_state == LOAD) begin
                r_pix <= r_pix + PIX_ONE;
            end
        end
    end

    // Read strobe runs one pixel ahead of datain; no read follows the last pixel.
    always_comb begin
        img_rd_en   = 1'b0;
        img_rd_addr = '0;
        if ((r_state == ISSUE) && (r_cmd == CMD_LOAD)) begin
            img_rd_en = 1'b1;
        end else if ((r_state == LOAD) && (r_pix != LAST_PIX)) begin
            img_rd_en   = 1'b1;
            img_rd_addr = ADDR_W'(r_pix + PIX_ONE);
        end
    end

    assign lcd_cmd_valid = (r_state == ISSUE);
    assign lcd_cmd       = r_cmd;
    assign grant_id      = r_gid;
    assign drop          = r_drop;
    assign lcd_datain    = (r_state == LOAD) ? img_rd_data : 8'h00;
    assign idle          = (r_state == IDLE) && w_empty0 && w_empty1;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Self-checking bench for lcd_cmd_sched: directed table, corner sequences and
// randomized traffic against a queue/timeline reference model.
module tb_lcd_cmd_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] req0_cmd, req1_cmd;
    logic       req0_valid, req1_valid, lcd_busy;
    logic [7:0] img_rd_data;
    logic       req0_ready, req1_ready, drop, img_rd_en, lcd_cmd_valid, grant_id, idle;
    logic [5:0] img_rd_addr;
    logic [2:0] lcd_cmd;
    logic [7:0] lcd_datain;

    always #5 clk = ~clk;

    lcd_cmd_sched #(
        .FIFO_DEPTH (4),
        .N_PIX      (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req0_cmd      (req0_cmd),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req1_cmd      (req1_cmd),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .drop          (drop),
        .img_rd_en     (img_rd_en),
        .img_rd_addr   (img_rd_addr),
        .img_rd_data   (img_rd_data),
        .lcd_cmd       (lcd_cmd),
        .lcd_cmd_valid (lcd_cmd_valid),
        .lcd_datain    (lcd_datain),
        .lcd_busy      (lcd_busy),
        .grant_id      (grant_id),
        .idle          (idle)
    );

    // Synchronous image memory: data valid the cycle after the strobe.
    logic [7:0] mem [64];
    always @(posedge clk) if (img_rd_en) img_rd_data <= mem[img_rd_addr];

    int checks = 0;
    int errors = 0;

    // Reference model: per-requester queues plus the issue timeline.
    int       cyc = 0;
    int       q0[$];
    int       q1[$];
    int       free_at, issue_at, exp_cmd, exp_gid, last_ptr, exp_drop;
    bit       is_load;
    int       iss_cmd[$];
    int       iss_gid[$];
    int       iss_cyc[$];

    typedef struct {
        bit   req;
        logic [2:0] cmd;
        int   exp_valid;
        int   exp_cmd;
        int   exp_gid;
        int   exp_drop;
        int   exp_len;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        free_at  = cyc;
        issue_at = cyc - 1000;
        is_load  = 1'b0;
        exp_cmd  = 0;
        exp_gid  = 0;
        last_ptr = 1;
        exp_drop = 0;
    endtask

    task automatic clear_log();
        iss_cmd.delete();
        iss_gid.delete();
        iss_cyc.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " lcd_cmd"}, lcd_cmd, 0);
        chk({tag, " cmd_valid"}, lcd_cmd_valid, 0);
        chk({tag, " datain"}, lcd_datain, 0);
        chk({tag, " rd_en"}, img_rd_en, 0);
        chk({tag, " rd_addr"}, img_rd_addr, 0);
        chk({tag, " drop"}, drop, 0);
        chk({tag, " grant_id"}, grant_id, 0);
        chk({tag, " req0_ready"}, req0_ready, 1);
        chk({tag, " req1_ready"}, req1_ready, 1);
        chk({tag, " idle"}, idle, 1);
    endtask

    // One clock cycle: compare at the falling edge, then advance the model.
    task automatic tick();
        int  k, w, c, exp_dat;
        bit  r0, r1, ld_win;
        @(negedge clk);
        k      = cyc - issue_at;
        ld_win = is_load && (k >= 0) && (k < 64);
        chk("cmd_valid", lcd_cmd_valid, int'(k == 0));
        chk("lcd_cmd", lcd_cmd, exp_cmd);
        chk("grant_id", grant_id, exp_gid);
        chk("img_rd_en", img_rd_en, int'(ld_win));
        if (ld_win) chk("img_rd_addr", img_rd_addr, k);
        exp_dat = 0;
        if (is_load && (k >= 1) && (k <= 64)) exp_dat = mem[k-1];
        chk("lcd_datain", lcd_datain, exp_dat);
        chk("req0_ready", req0_ready, int'(q0.size() < 4));
        chk("req1_ready", req1_ready, int'(q1.size() < 4));
        chk("idle", idle, int'((cyc >= free_at) && (q0.size() == 0) && (q1.size() == 0)));
        chk("drop", drop, exp_drop);
        if (lcd_cmd_valid) begin
            iss_cmd.push_back(int'(lcd_cmd));
            iss_gid.push_back(int'(grant_id));
            iss_cyc.push_back(cyc);
        end
        r0 = (q0.size() < 4);
        r1 = (q1.size() < 4);
        if ((cyc >= free_at) && !lcd_busy && ((q0.size() > 0) || (q1.size() > 0))) begin
            if ((q0.size() > 0) && (q1.size() > 0)) w = 1 - last_ptr;
            else w = (q0.size() > 0) ? 0 : 1;
            c        = (w == 1) ? q1.pop_front() : q0.pop_front();
            exp_cmd  = c;
            exp_gid  = w;
            last_ptr = w;
            issue_at = cyc + 1;
            is_load  = (c == 1);
            free_at  = cyc + 1 + (is_load ? 66 : 2);
        end
        exp_drop = 0;
        if (req0_valid && r0) begin
            if (req0_cmd <= 3'd5) q0.push_back(int'(req0_cmd));
            else exp_drop = 1;
        end
        if (req1_valid && r1) begin
            if (req1_cmd <= 3'd5) q1.push_back(int'(req1_cmd));
            else exp_drop = 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(output int at);
        int n = 0;
        while (!idle && (n < 300)) begin
            tick();
            n++;
        end
        chk("idle within bound", idle, 1);
        at = cyc;
    endtask

    task automatic wait_issues(input int num, input int bound);
        int n = 0;
        while ((iss_cyc.size() < num) && (n < bound)) begin
            tick();
            n++;
        end
        chk("issue count", iss_cyc.size(), num);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int t, c, ic, fall;
        int exp_ord[8];
        int p0[4];
        int p1[4];
        int busy_cmds[5];
        exp_ord   = '{0, 5, 2, 0, 3, 2, 4, 3};
        p0        = '{0, 2, 3, 4};
        p1        = '{5, 0, 2, 3};
        busy_cmds = '{2, 3, 4, 5, 0};

        vecs[0] = '{1'b0, 3'd0, 1, 0, 0, 0, 2};
        vecs[1] = '{1'b1, 3'd4, 1, 4, 1, 0, 2};
        vecs[2] = '{1'b1, 3'd5, 1, 5, 1, 0, 2};
        vecs[3] = '{1'b0, 3'd6, 0, 5, 1, 1, 0};
        vecs[4] = '{1'b1, 3'd7, 0, 5, 1, 1, 0};
        vecs[5] = '{1'b0, 3'd2, 1, 2, 0, 0, 2};
        vecs[6] = '{1'b1, 3'd1, 1, 1, 1, 0, 66};

        for (int k = 0; k < 64; k++) mem[k] = 8'(k);
        req0_cmd = 3'd0; req1_cmd = 3'd0;
        req0_valid = 1'b0; req1_valid = 1'b0; lcd_busy = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        clear_log();

        // Single Load from requester 0.
        req0_cmd = 3'd1; req0_valid = 1'b1;
        t = cyc;
        tick();
        req0_valid = 1'b0;
        tick();
        c = cyc;
        chk("load cmd_valid at t+2", lcd_cmd_valid, 1);
        chk("load issue cycle", c - t, 2);
        run_until_idle(ic);
        chk("load idle at c+66", ic - c, 66);

        // Directed single-command table.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].req) begin
                req1_cmd = vecs[i].cmd; req1_valid = 1'b1;
            end else begin
                req0_cmd = vecs[i].cmd; req0_valid = 1'b1;
            end
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            chk("vec drop", drop, vecs[i].exp_drop);
            tick();
            chk("vec cmd_valid", lcd_cmd_valid, vecs[i].exp_valid);
            chk("vec lcd_cmd", lcd_cmd, vecs[i].exp_cmd);
            chk("vec grant_id", grant_id, vecs[i].exp_gid);
            c = cyc;
            run_until_idle(ic);
            chk("vec active length", ic - c, vecs[i].exp_len);
        end

        // Both requesters push four commands in the same cycles.
        clear_log();
        for (int i = 0; i < 4; i++) begin
            req0_cmd = 3'(p0[i]); req1_cmd = 3'(p1[i]);
            req0_valid = 1'b1; req1_valid = 1'b1;
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_issues(8, 200);
        for (int i = 0; i < iss_cmd.size() && i < 8; i++) begin
            chk("rr order cmd", iss_cmd[i], exp_ord[i]);
            chk("rr order gid", iss_gid[i], i % 2);
        end
        run_until_idle(ic);

        // Busy held high while requester 1 overfills its FIFO.
        lcd_busy = 1'b1;
        tick();
        clear_log();
        for (int i = 0; i < 5; i++) begin
            req1_cmd = 3'(busy_cmds[i]); req1_valid = 1'b1;
            if (i == 4) chk("req1_ready after 4 pushes", req1_ready, 0);
            tick();
        end
        req1_valid = 1'b0;
        repeat (10) tick();
        chk("no issue while busy", iss_cyc.size(), 0);
        lcd_busy = 1'b0;
        fall = cyc;
        wait_issues(4, 100);
        for (int i = 0; i < iss_cmd.size() && i < 4; i++)
            chk("busy drain cmd", iss_cmd[i], busy_cmds[i]);
        if (iss_cyc.size() > 0) chk("issue after busy low", iss_cyc[0] - fall, 1);
        run_until_idle(ic);

        // Busy rises in HOLD after a shift and stays high for 10 cycles.
        clear_log();
        req0_cmd = 3'd2; req0_valid = 1'b1;
        tick();
        req0_cmd = 3'd3;
        tick();
        req0_valid = 1'b0;
        chk("shift issued", lcd_cmd_valid, 1);
        tick();
        lcd_busy = 1'b1;
        repeat (10) tick();
        lcd_busy = 1'b0;
        fall = cyc;
        wait_issues(2, 50);
        if (iss_cyc.size() > 1) begin
            chk("post-busy issue delay", iss_cyc[1] - (fall - 1), 2);
            chk("post-busy cmd", iss_cmd[1], 3);
        end
        run_until_idle(ic);

        // Reset asserted mid-Load while another command is queued.
        req0_cmd = 3'd1; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        c = cyc;
        repeat (5) tick();
        req1_cmd = 3'd3; req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        while (cyc < c + 21) tick();
        chk("pixel 20 before reset", lcd_datain, 20);
        reset = 1'b0;
        #1;
        chk_reset_vals("midload");
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        clear_log();
        repeat (80) tick();
        chk("no issue after reset", iss_cyc.size(), 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 64; k++) mem[k] = 8'($urandom_range(0, 255));
        for (int n = 0; n < 2500; n++) begin
            req0_valid = ($urandom_range(0, 3) == 0);
            req1_valid = ($urandom_range(0, 3) == 0);
            req0_cmd   = 3'($urandom_range(0, 7));
            req1_cmd   = 3'($urandom_range(0, 7));
            lcd_busy   = ($urandom_range(0, 9) < 2);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
